exmem_mem_access: RTL and testbench

- EX/MEM pipeline register plus data-memory access engine, directly upstream of the MEM/WB stage.
- Latches the executed instruction, its ALU result and its PC.
- Runs loads/stores against the data memory over a req/ack handshake, splitting word-crossing accesses into two aligned beats.
- Delivers raw read data and a pre-normalized merged word to MEM/WB, and holds the pipeline via a stall while memory is busy.

---
 rtl/exmem_mem_access.sv | 239 +++++++++++++++++++++++
 tb/tb_exmem_mem_access.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exmem_mem_access.sv
// EX/MEM pipeline register with a data-memory access engine (req/ack, up to two aligned beats).
// Optional macro UNALIGNED_ACCESS_EN enables word-crossing (split) accesses; otherwise they are dropped.
module exmem_mem_access #(
   parameter logic [31:0] NOP_INSTR    = 32'h00000013,
   parameter logic [6:0]  LOAD_OPCODE  = 7'b0000011,
   parameter logic [6:0]  STORE_OPCODE = 7'b0100011
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid_i,
   input  logic [31:0] ex_ir_i,
   input  logic [31:0] ex_pc_i,
   input  logic [31:0] ex_alu_out_i,
   input  logic [31:0] ex_store_data_i,
   output logic        stall_o,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [31:0] dmem_wdata_o,
   output logic [3:0]  dmem_be_o,
   input  logic        dmem_ack_i,
   input  logic [31:0] dmem_rdata_i,
   output logic [31:0] exmem_ir_o,
   output logic [31:0] exmem_pc_o,
   output logic [31:0] exmem_alu_out_o,
   output logic [31:0] read_data_o,
   output logic [31:0] merged_word_o,
   output logic        memory_operation_o
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_BEAT0 = 3'd1,
      ST_BEAT1 = 3'd2,
      ST_DROP  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   function automatic logic [3:0] size_mask(input logic [1:0] f3_lo);
      case (f3_lo)
         2'b00:   size_mask = 4'b0001;
         2'b01:   size_mask = 4'b0011;
         default: size_mask = 4'b1111;
      endcase
   endfunction

   function automatic logic is_split(input logic [1:0] off, input logic [1:0] f3_lo);
      logic [2:0] v_size;
      case (f3_lo)
         2'b00:   v_size = 3'd1;
         2'b01:   v_size = 3'd2;
         default: v_size = 3'd4;
      endcase
      is_split = (({1'b0, off} + v_size) > 3'd4);
   endfunction

   function automatic logic [3:0] beat0_be(input logic [3:0] mask, input logic [1:0] off);
      logic [7:0] v_wide;
      v_wide   = {4'b0000, mask} << off;
      beat0_be = v_wide[3:0];
   endfunction

   function automatic logic [31:0] normalize(input logic [31:0] w, input logic [2:0] f3);
      case (f3)
         3'b000:  normalize = {{24{w[7]}}, w[7:0]};
         3'b001:  normalize = {{16{w[15]}}, w[15:0]};
         3'b100:  normalize = {24'h000000, w[7:0]};
         3'b101:  normalize = {16'h0000, w[15:0]};
         default: normalize = w;
      endcase
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] hi, input logic [31:0] lo,
                                         input logic [1:0] off);
      logic [63:0] v_cat;
      v_cat = {hi, lo} >> {off, 3'b000};
      merge = v_cat[31:0];
   endfunction

   state_t      r_state;
   logic [31:0] r_ir;
   logic [31:0] r_pc;
   logic [31:0] r_addr;
   logic [31:0] r_sdata;
   logic [31:0] r_lo;

   logic [6:0]  w_opcode;
   logic        w_is_load;
   logic        w_is_store;
   logic        w_is_mem;
   logic [1:0]  w_in_off;
   logic [3:0]  w_in_mask;
   logic [1:0]  w_off;
   logic [2:0]  w_f3;
   logic [3:0]  w_mask;
   logic        w_split;
   logic [2:0]  w_hi_shift;
   logic [3:0]  w_be1;
   logic [31:0] w_wdata1;
`ifndef UNALIGNED_ACCESS_EN
   logic        w_in_split;
`endif

   assign w_opcode   = ex_ir_i[6:0];
   assign w_is_load  = (w_opcode == LOAD_OPCODE);
   assign w_is_store = (w_opcode == STORE_OPCODE);
   assign w_is_mem   = w_is_load | w_is_store;
   assign w_in_off   = ex_alu_out_i[1:0];
   assign w_in_mask  = size_mask(ex_ir_i[13:12]);
`ifndef UNALIGNED_ACCESS_EN
   assign w_in_split = is_split(w_in_off, ex_ir_i[13:12]);
`endif

   // Second-beat lanes carry the bytes that spilled past the first word.
   assign w_off      = r_addr[1:0];
   assign w_f3       = r_ir[14:12];
   assign w_mask     = size_mask(w_f3[1:0]);
   assign w_split    = is_split(w_off, w_f3[1:0]);
   assign w_hi_shift = 3'd4 - {1'b0, w_off};
   assign w_be1      = w_mask >> w_hi_shift;
   assign w_wdata1   = r_sdata >> {w_hi_shift, 3'b000};

   // Access sequencer, pipeline register and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state            <= ST_IDLE;
         r_ir               <= NOP_INSTR;
         r_pc               <= 32'h0000_0000;
         r_addr             <= 32'h0000_0000;
         r_sdata            <= 32'h0000_0000;
         r_lo               <= 32'h0000_0000;
         stall_o            <= 1'b0;
         dmem_req_o         <= 1'b0;
         dmem_we_o          <= 1'b0;
         dmem_addr_o        <= 32'h0000_0000;
         dmem_wdata_o       <= 32'h0000_0000;
         dmem_be_o          <= 4'b0000;
         exmem_ir_o         <= NOP_INSTR;
         exmem_pc_o         <= 32'h0000_0000;
         exmem_alu_out_o    <= 32'h0000_0000;
         read_data_o        <= 32'h0000_0000;
         merged_word_o      <= 32'h0000_0000;
         memory_operation_o <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (ex_valid_i && w_is_mem) begin
                  r_ir               <= ex_ir_i;
                  r_pc               <= ex_pc_i;
                  r_addr             <= ex_alu_out_i;
                  r_sdata            <= ex_store_data_i;
                  stall_o            <= 1'b1;
                  exmem_ir_o         <= NOP_INSTR;
                  memory_operation_o <= 1'b0;
`ifndef UNALIGNED_ACCESS_EN
                  if (w_in_split) begin
                     r_state    <= ST_DROP;
                     dmem_req_o <= 1'b0;
                  end else
`endif
                  begin
                     r_state      <= ST_BEAT0;
                     dmem_req_o   <= 1'b1;
                     dmem_we_o    <= w_is_store;
                     dmem_addr_o  <= {ex_alu_out_i[31:2], 2'b00};
                     dmem_be_o    <= beat0_be(w_in_mask, w_in_off);
                     dmem_wdata_o <= w_is_store ? (ex_store_data_i << {w_in_off, 3'b000})
                                                : 32'h0000_0000;
                  end
               end else begin
                  r_state            <= ST_IDLE;
                  stall_o            <= 1'b0;
                  exmem_ir_o         <= ex_valid_i ? ex_ir_i : NOP_INSTR;
                  exmem_pc_o         <= ex_pc_i;
                  exmem_alu_out_o    <= ex_alu_out_i;
                  memory_operation_o <= 1'b0;
               end
            end
            ST_BEAT0: begin
               if (dmem_ack_i) begin
                  r_lo <= dmem_rdata_i;
                  if (w_split) begin
                     r_state      <= ST_BEAT1;
                     dmem_addr_o  <= dmem_addr_o + 32'd4;
                     dmem_be_o    <= w_be1;
                     dmem_wdata_o <= dmem_we_o ? w_wdata1 : 32'h0000_0000;
                  end else begin
                     r_state            <= ST_DONE;
                     stall_o            <= 1'b0;
                     dmem_req_o         <= 1'b0;
                     dmem_we_o          <= 1'b0;
                     dmem_be_o          <= 4'b0000;
                     exmem_ir_o         <= r_ir;
                     exmem_pc_o         <= r_pc;
                     exmem_alu_out_o    <= r_addr;
                     memory_operation_o <= 1'b1;
                     read_data_o        <= dmem_rdata_i;
                     merged_word_o      <= normalize(merge(32'h0000_0000, dmem_rdata_i, w_off), w_f3);
                  end
               end else begin
                  r_state <= ST_BEAT0;
               end
            end
            ST_BEAT1: begin
               if (dmem_ack_i) begin
                  r_state            <= ST_DONE;
                  stall_o            <= 1'b0;
                  dmem_req_o         <= 1'b0;
                  dmem_we_o          <= 1'b0;
                  dmem_be_o          <= 4'b0000;
                  exmem_ir_o         <= r_ir;
                  exmem_pc_o         <= r_pc;
                  exmem_alu_out_o    <= r_addr;
                  memory_operation_o <= 1'b1;
                  read_data_o        <= r_lo;
                  merged_word_o      <= normalize(merge(dmem_rdata_i, r_lo, w_off), w_f3);
               end else begin
                  r_state <= ST_BEAT1;
               end
            end
            ST_DROP: begin
               // Unsupported word-crossing access retires as a bubble.
               r_state            <= ST_DONE;
               stall_o            <= 1'b0;
               exmem_ir_o         <= NOP_INSTR;
               exmem_pc_o         <= r_pc;
               exmem_alu_out_o    <= r_addr;
               memory_operation_o <= 1'b0;
            end
            default: begin
               r_state    <= ST_IDLE;
               stall_o    <= 1'b0;
               dmem_req_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_exmem_mem_access.sv
// Directed self-checking bench for exmem_mem_access with a wait-state programmable memory responder.
// Split-access expectations follow UNALIGNED_ACCESS_EN.
module tb_exmem_mem_access;

   logic        clk;
   logic        rst;
   logic        ex_valid_i;
   logic [31:0] ex_ir_i;
   logic [31:0] ex_pc_i;
   logic [31:0] ex_alu_out_i;
   logic [31:0] ex_store_data_i;
   logic        stall_o;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [31:0] dmem_wdata_o;
   logic [3:0]  dmem_be_o;
   logic        dmem_ack_i;
   logic [31:0] dmem_rdata_i;
   logic [31:0] exmem_ir_o;
   logic [31:0] exmem_pc_o;
   logic [31:0] exmem_alu_out_o;
   logic [31:0] read_data_o;
   logic [31:0] merged_word_o;
   logic        memory_operation_o;

   exmem_mem_access dut (
      .clk                (clk),
      .rst                (rst),
      .ex_valid_i         (ex_valid_i),
      .ex_ir_i            (ex_ir_i),
      .ex_pc_i            (ex_pc_i),
      .ex_alu_out_i       (ex_alu_out_i),
      .ex_store_data_i    (ex_store_data_i),
      .stall_o            (stall_o),
      .dmem_req_o         (dmem_req_o),
      .dmem_we_o          (dmem_we_o),
      .dmem_addr_o        (dmem_addr_o),
      .dmem_wdata_o       (dmem_wdata_o),
      .dmem_be_o          (dmem_be_o),
      .dmem_ack_i         (dmem_ack_i),
      .dmem_rdata_i       (dmem_rdata_i),
      .exmem_ir_o         (exmem_ir_o),
      .exmem_pc_o         (exmem_pc_o),
      .exmem_alu_out_o    (exmem_alu_out_o),
      .read_data_o        (read_data_o),
      .merged_word_o      (merged_word_o),
      .memory_operation_o (memory_operation_o)
   );

   localparam logic [31:0] I_ADDI = 32'h00500093;
   localparam logic [31:0] I_LW   = 32'h00002083;
   localparam logic [31:0] I_LH   = 32'h00001083;
   localparam logic [31:0] I_LB   = 32'h00000083;
   localparam logic [31:0] I_LBU  = 32'h00004083;
   localparam logic [31:0] I_SW   = 32'h00002023;
   localparam logic [31:0] I_SB   = 32'h00000023;
   localparam logic [31:0] I_NOP  = 32'h00000013;

   int tests_run;
   int tests_failed;

   logic [31:0] mem [0:255];
   int          cfg_wait;
   int          wait_left;
   bit          fresh;
   int          req_cycles;
   int          n_beats;
   logic [31:0] beat_addr  [0:3];
   logic [31:0] beat_wdata [0:3];
   logic [3:0]  beat_be    [0:3];
   logic        beat_we    [0:3];
   int          cyc;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Memory responder: acks each beat after cfg_wait wait cycles and logs the beat.
   initial begin
      dmem_ack_i   = 1'b0;
      dmem_rdata_i = 32'h0;
      fresh        = 1'b1;
      wait_left    = 0;
      forever begin
         @(negedge clk);
         if (dmem_req_o === 1'b1) begin
            req_cycles++;
            if (fresh) begin
               wait_left = cfg_wait;
               fresh     = 1'b0;
            end
            if (wait_left == 0) begin
               dmem_ack_i   = 1'b1;
               dmem_rdata_i = mem[dmem_addr_o[9:2]];
               if (n_beats < 4) begin
                  beat_addr[n_beats]  = dmem_addr_o;
                  beat_wdata[n_beats] = dmem_wdata_o;
                  beat_be[n_beats]    = dmem_be_o;
                  beat_we[n_beats]    = dmem_we_o;
               end
               n_beats++;
               if (dmem_we_o) begin
                  for (int b = 0; b < 4; b++)
                     if (dmem_be_o[b]) mem[dmem_addr_o[9:2]][8*b +: 8] = dmem_wdata_o[8*b +: 8];
               end
               fresh = 1'b1;
            end else begin
               dmem_ack_i = 1'b0;
               wait_left--;
            end
         end else begin
            dmem_ack_i = 1'b0;
            fresh      = 1'b1;
         end
      end
   end

   // Presents one instruction at the current negedge and waits out the stall window.
   task automatic run_op(input logic [31:0] ir, input logic [31:0] pc, input logic [31:0] addr,
                         input logic [31:0] sd, input int wt, output int cycles);
      cfg_wait        = wt;
      n_beats         = 0;
      req_cycles      = 0;
      ex_valid_i      = 1'b1;
      ex_ir_i         = ir;
      ex_pc_i         = pc;
      ex_alu_out_i    = addr;
      ex_store_data_i = sd;
      @(negedge clk);
      cycles = 0;
      while (stall_o && cycles < 200) begin
         cycles++;
         @(negedge clk);
      end
      ex_valid_i = 1'b0;
      ex_ir_i    = 32'h0;
   endtask

   task automatic idle(input int n);
      ex_valid_i = 1'b0;
      for (int k = 0; k < n; k++) @(negedge clk);
   endtask

   initial begin
      tests_run = 0; tests_failed = 0;
      cfg_wait = 0; req_cycles = 0; n_beats = 0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[8'h40] = 32'hDEADBEEF;
      mem[8'h80] = 32'h11111111;
      mem[8'h81] = 32'h22222222;
      mem[8'hC0] = 32'h0000F700;
      rst = 1'b1;
      ex_valid_i = 1'b0; ex_ir_i = 32'h0; ex_pc_i = 32'h0;
      ex_alu_out_i = 32'h0; ex_store_data_i = 32'h0;
      repeat (2) @(negedge clk);
      check_eq("rst_ir", exmem_ir_o, I_NOP);
      check_eq("rst_stall", {31'h0, stall_o}, 32'h0);
      check_eq("rst_req", {31'h0, dmem_req_o}, 32'h0);
      check_eq("rst_be", {28'h0, dmem_be_o}, 32'h0);
      check_eq("rst_memop", {31'h0, memory_operation_o}, 32'h0);
      rst = 1'b0;
      idle(2);

      // Non-memory instruction passes straight through
      run_op(I_ADDI, 32'h40, 32'h5, 32'h0, 0, cyc);
      check_eq("addi_stall", cyc, 0);
      check_eq("addi_ir", exmem_ir_o, I_ADDI);
      check_eq("addi_pc", exmem_pc_o, 32'h40);
      check_eq("addi_memop", {31'h0, memory_operation_o}, 32'h0);
      check_eq("addi_req", req_cycles, 0);
      idle(1);
      check_eq("bubble_ir", exmem_ir_o, I_NOP);

      // Aligned word load, two wait states
      run_op(I_LW, 32'h44, 32'h100, 32'h0, 2, cyc);
      check_eq("lw_stall", cyc, 3);
      check_eq("lw_rdata", read_data_o, 32'hDEADBEEF);
      check_eq("lw_merged", merged_word_o, 32'hDEADBEEF);
      check_eq("lw_memop", {31'h0, memory_operation_o}, 32'h1);
      check_eq("lw_ir", exmem_ir_o, I_LW);
      check_eq("lw_alu", exmem_alu_out_o, 32'h100);
      check_eq("lw_addr", beat_addr[0], 32'h100);
      idle(2);

      // Half load at offset 2 stays within one word
      run_op(I_LH, 32'h48, 32'h102, 32'h0, 0, cyc);
      check_eq("lh2_beats", n_beats, 1);
      check_eq("lh2_merged", merged_word_o, 32'hFFFFDEAD);
      check_eq("lh2_alu", exmem_alu_out_o, 32'h102);
      idle(1);

      // Word-crossing half load
      mem[8'h40] = 32'h80AABBCC;
      mem[8'h41] = 32'h11223380;
      run_op(I_LH, 32'h4C, 32'h103, 32'h0, 0, cyc);
`ifdef UNALIGNED_ACCESS_EN
      check_eq("lh3_beats", n_beats, 2);
      check_eq("lh3_addr0", beat_addr[0], 32'h100);
      check_eq("lh3_addr1", beat_addr[1], 32'h104);
      check_eq("lh3_stall", cyc, 2);
      check_eq("lh3_merged", merged_word_o, 32'hFFFF8080);
      check_eq("lh3_rdata", read_data_o, 32'h80AABBCC);
      check_eq("lh3_memop", {31'h0, memory_operation_o}, 32'h1);
`else
      check_eq("lh3_req", req_cycles, 0);
      check_eq("lh3_stall", cyc, 1);
      check_eq("lh3_ir", exmem_ir_o, I_NOP);
      check_eq("lh3_memop", {31'h0, memory_operation_o}, 32'h0);
`endif
      idle(1);

      // Word-crossing store, one wait state per beat
      run_op(I_SW, 32'h50, 32'h202, 32'hA1B2C3D4, 1, cyc);
`ifdef UNALIGNED_ACCESS_EN
      check_eq("sw_beats", n_beats, 2);
      check_eq("sw_stall", cyc, 4);
      check_eq("sw_addr0", beat_addr[0], 32'h200);
      check_eq("sw_be0", {28'h0, beat_be[0]}, 32'hC);
      check_eq("sw_wd0", beat_wdata[0], 32'hC3D40000);
      check_eq("sw_we0", {31'h0, beat_we[0]}, 32'h1);
      check_eq("sw_addr1", beat_addr[1], 32'h204);
      check_eq("sw_be1", {28'h0, beat_be[1]}, 32'h3);
      check_eq("sw_wd1", beat_wdata[1], 32'h0000A1B2);
      check_eq("sw_mem0", mem[8'h80], 32'hC3D41111);
      check_eq("sw_mem1", mem[8'h81], 32'h2222A1B2);
      check_eq("sw_memop", {31'h0, memory_operation_o}, 32'h1);
`else
      check_eq("sw_req", req_cycles, 0);
      check_eq("sw_stall", cyc, 1);
      check_eq("sw_ir", exmem_ir_o, I_NOP);
      check_eq("sw_mem0", mem[8'h80], 32'h11111111);
`endif
      idle(1);

      // Byte store in the top lane does not split
      mem[8'h80] = 32'h11111111;
      run_op(I_SB, 32'h54, 32'h203, 32'h000000A5, 0, cyc);
      check_eq("sb_beats", n_beats, 1);
      check_eq("sb_be", {28'h0, beat_be[0]}, 32'h8);
      check_eq("sb_wd", beat_wdata[0], 32'hA5000000);
      check_eq("sb_mem", mem[8'h80], 32'hA5111111);
      idle(1);

      // Signed byte load from an odd offset
      run_op(I_LB, 32'h58, 32'h301, 32'h0, 0, cyc);
      check_eq("lb_merged", merged_word_o, 32'hFFFFFFF7);
      idle(1);

      // Zero-wait LBU followed by an LW accepted in the DONE cycle
      mem[8'h40] = 32'hDEADBEEF;
      run_op(I_LBU, 32'h5C, 32'h301, 32'h0, 0, cyc);
      check_eq("lbu_stall", cyc, 1);
      check_eq("lbu_merged", merged_word_o, 32'h000000F7);
      check_eq("lbu_rdata", read_data_o, 32'h0000F700);
      check_eq("lbu_ir", exmem_ir_o, I_LBU);
      run_op(I_LW, 32'h60, 32'h100, 32'h0, 0, cyc);
      check_eq("b2b_stall", cyc, 1);
      check_eq("b2b_rdata", read_data_o, 32'hDEADBEEF);
      check_eq("b2b_pc", exmem_pc_o, 32'h60);
      idle(1);

      // Asynchronous reset in the middle of a beat
      cfg_wait = 5; n_beats = 0;
      ex_valid_i = 1'b1; ex_ir_i = I_LW; ex_pc_i = 32'h64; ex_alu_out_i = 32'h100;
      @(negedge clk);
      ex_valid_i = 1'b0;
      check_eq("mid_req_before", {31'h0, dmem_req_o}, 32'h1);
      #1 rst = 1'b1;
      #1;
      check_eq("mid_req", {31'h0, dmem_req_o}, 32'h0);
      check_eq("mid_ir", exmem_ir_o, I_NOP);
      check_eq("mid_stall", {31'h0, stall_o}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      req_cycles = 0;
      idle(4);
      check_eq("mid_noretry", req_cycles, 0);
      check_eq("mid_beats", n_beats, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
